// File: rtl/regfile_alu_pkg.sv
// Shared types, constants and decode helpers for the RegFile/ALU sequencer.
package regfile_alu_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FLAG_W    = 5;
    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned OPC_W     = 5;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned IMM8_W    = 8;

    localparam int unsigned MAJOR_LSB = 12;
    localparam int unsigned RDEST_LSB = 8;
    localparam int unsigned EXT_LSB   = 4;
    localparam int unsigned RSRC_LSB  = 0;

    localparam logic [CODE_W-1:0] OP_AND = 4'h1;
    localparam logic [CODE_W-1:0] OP_OR  = 4'h2;
    localparam logic [CODE_W-1:0] OP_XOR = 4'h3;
    localparam logic [CODE_W-1:0] OP_ADD = 4'h5;
    localparam logic [CODE_W-1:0] OP_SUB = 4'h9;
    localparam logic [CODE_W-1:0] OP_CMP = 4'hB;
    localparam logic [CODE_W-1:0] OP_MOV = 4'hD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        EXEC = 2'd2
    } seqStateT;

    typedef struct packed {
        logic [OPC_W-1:0]  opCode;
        logic [REG_W-1:0]  rdest;
        logic [REG_W-1:0]  rsrc;
        logic [DATA_W-1:0] imm;
        logic              immSel;
        logic              wrEn;
        logic              isNop;
    } decodeT;

    function automatic logic is_logical(input logic [CODE_W-1:0] code);
        return (code == OP_AND) || (code == OP_OR) || (code == OP_XOR);
    endfunction

    function automatic logic is_cmp(input logic [CODE_W-1:0] code);
        return code == OP_CMP;
    endfunction

endpackage

// File: rtl/regfile_alu_seq_if.sv
// Instruction handshake plus datapath control/status bundle for the sequencer.
interface regfile_alu_seq_if import regfile_alu_pkg::*; ;

    logic                InstrValid;
    logic                InstrReady;
    logic [INSTR_W-1:0]  Instr;
    logic [FLAG_W-1:0]   Flags;
    logic [DATA_W-1:0]   AluOutput;
    logic [REG_W-1:0]    RdestRegLoc;
    logic [REG_W-1:0]    RsrcRegLoc;
    logic [OPC_W-1:0]    OpCode;
    logic [DATA_W-1:0]   Imm;
    logic                Imm_s;
    logic                En;
    logic [FLAG_W-1:0]   Psr;
    logic [DATA_W-1:0]   Result;
    logic                Done;

    modport slave (
        input  InstrValid, Instr, Flags, AluOutput,
        output InstrReady, RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s,
               En, Psr, Result, Done
    );

    modport master (
        output InstrValid, Instr, Flags, AluOutput,
        input  InstrReady, RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s,
               En, Psr, Result, Done
    );

endinterface

// File: rtl/regfile_alu_seq_instr_decode.sv
// Combinational field decode of the latched instruction word.
module instr_decode
    import regfile_alu_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output decodeT             dec
);

    logic [CODE_W-1:0] major;
    logic [CODE_W-1:0] ext;
    logic [CODE_W-1:0] code;
    logic [IMM8_W-1:0] imm8;

    assign major = ir[MAJOR_LSB +: CODE_W];
    assign ext   = ir[EXT_LSB +: CODE_W];
    assign imm8  = ir[0 +: IMM8_W];
    assign code  = (major == '0) ? ext : major;

    always_comb begin
        dec        = '0;
        dec.rdest  = ir[RDEST_LSB +: REG_W];
        dec.rsrc   = ir[RSRC_LSB +: REG_W];
        if (major == '0) begin
            dec.opCode = {1'b0, ext};
            dec.immSel = 1'b0;
        end else begin
            dec.opCode = {1'b0, major};
            dec.immSel = 1'b1;
            // Logical ops take a zero-extended mask; arithmetic ops a signed offset
            if (is_logical(major))
                dec.imm = DATA_W'(imm8);
            else
                dec.imm = {{(DATA_W-IMM8_W){imm8[IMM8_W-1]}}, imm8};
        end
        dec.isNop = (ir == '0);
        dec.wrEn  = !dec.isNop && !is_cmp(code);
    end

endmodule

// File: rtl/regfile_alu_seq.sv
// Three-cycle sequencer (IDLE/OPER/EXEC) driving the RegFile/ALU pair and
// latching ALU flags and result.
module regfile_alu_seq
    import regfile_alu_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    regfile_alu_seq_if.slave  bus
);

    seqStateT           state;
    seqStateT           nextState;
    logic [INSTR_W-1:0] instrReg;
    decodeT             dec;
    logic               accept;

    assign accept = bus.InstrValid && bus.InstrReady;

    instr_decode uDecode (
        .ir  (instrReg),
        .dec (dec)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = OPER;
            OPER:    nextState = EXEC;
            EXEC:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // En follows state directly so an async reset drops it without waiting for an edge
    always_comb begin
        bus.InstrReady = 1'b0;
        bus.En         = 1'b0;
        case (state)
            IDLE:    bus.InstrReady = 1'b1;
            EXEC:    bus.En         = dec.wrEn;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)         instrReg <= '0;
        else if (accept) instrReg <= bus.Instr;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bus.Psr    <= '0;
            bus.Result <= '0;
            bus.Done   <= 1'b0;
        end else begin
            bus.Done <= (state == EXEC);
            if (state == EXEC) begin
                bus.Result <= bus.AluOutput;
                if (!dec.isNop) bus.Psr <= bus.Flags;
            end
        end
    end

    assign bus.RdestRegLoc = dec.rdest;
    assign bus.RsrcRegLoc  = dec.rsrc;
    assign bus.OpCode      = dec.opCode;
    assign bus.Imm         = dec.imm;
    assign bus.Imm_s       = dec.immSel;

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed bench for regfile_alu_seq with a behavioural register file and ALU.
module tb_regfile_alu_seq;
    import regfile_alu_pkg::*;

    logic Clk = 1'b0;
    logic Rst;
    int   nChecks = 0;
    int   nFails  = 0;

    regfile_alu_seq_if bus ();

    regfile_alu_seq dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Datapath model: operands latched every edge, write-back when En is high
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] opA, opB, aluRes;
    logic [OPC_W-1:0]  opc;
    logic [FLAG_W-1:0] aluFl;
    logic [DATA_W:0]   wide;
    logic              preWe;
    logic [REG_W-1:0]  preAddr;
    logic [DATA_W-1:0] preData;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            opA <= '0;
            opB <= '0;
            opc <= '0;
        end else begin
            if (preWe) regs[preAddr] <= preData;
            opA <= regs[bus.RdestRegLoc];
            opB <= bus.Imm_s ? bus.Imm : regs[bus.RsrcRegLoc];
            opc <= bus.OpCode;
            if (bus.En) regs[bus.RdestRegLoc] <= bus.AluOutput;
        end
    end

    // Flags: [0]=Z [1]=N [2]=C/borrow [3]=V [4]=signed less-than
    always_comb begin
        wide   = '0;
        aluRes = opB;
        aluFl  = '0;
        case (opc)
            5'(OP_ADD): begin
                wide     = {1'b0, opA} + {1'b0, opB};
                aluRes   = wide[DATA_W-1:0];
                aluFl[2] = wide[DATA_W];
                aluFl[3] = (opA[15] == opB[15]) && (aluRes[15] != opA[15]);
            end
            5'(OP_SUB), 5'(OP_CMP): begin
                wide     = {1'b0, opA} - {1'b0, opB};
                aluRes   = wide[DATA_W-1:0];
                aluFl[2] = wide[DATA_W];
                aluFl[3] = (opA[15] != opB[15]) && (aluRes[15] != opA[15]);
                aluFl[4] = $signed(opA) < $signed(opB);
            end
            5'(OP_AND): aluRes = opA & opB;
            5'(OP_OR):  aluRes = opA | opB;
            5'(OP_XOR): aluRes = opA ^ opB;
            5'(OP_MOV): aluRes = opB;
            default:    aluRes = opB;
        endcase
        aluFl[0] = (aluRes == '0);
        aluFl[1] = aluRes[15];
    end

    assign bus.AluOutput = aluRes;
    assign bus.Flags     = aluFl;

    // Per-instruction observations filled in by runInstr
    int                rEnCnt, rEnFirst, rDoneLat, rDoneCnt;
    logic              rRdyN3, rImmS;
    logic [OPC_W-1:0]  rOpc;
    logic [DATA_W-1:0] rImm;

    task automatic preload(input int a, input logic [DATA_W-1:0] d);
        @(negedge Clk);
        preWe = 1'b1; preAddr = REG_W'(a); preData = d;
        @(negedge Clk);
        preWe = 1'b0;
    endtask

    task automatic runInstr(input logic [INSTR_W-1:0] w);
        int c;
        @(negedge Clk);
        bus.InstrValid = 1'b1;
        bus.Instr      = w;
        c = 0;
        while (!bus.InstrReady && c < 8) begin
            @(negedge Clk);
            c++;
        end
        nChecks++;
        if (bus.InstrReady !== 1'b1) begin
            nFails++;
            $display("FAIL accept_timeout: InstrReady=%b required 1", bus.InstrReady);
        end
        @(negedge Clk);
        bus.InstrValid = 1'b0;
        bus.Instr      = '0;
        rOpc = bus.OpCode; rImm = bus.Imm; rImmS = bus.Imm_s;
        rEnCnt = 0; rEnFirst = -1; rDoneLat = -1; rDoneCnt = 0; rRdyN3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (bus.En === 1'b1) begin
                rEnCnt++;
                if (rEnFirst < 0) rEnFirst = k;
            end
            if (bus.Done === 1'b1) begin
                rDoneCnt++;
                if (rDoneLat < 0) rDoneLat = k;
            end
            if (k == 3) rRdyN3 = bus.InstrReady;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        Rst = 1'b1; preWe = 1'b0; preAddr = '0; preData = '0;
        bus.InstrValid = 1'b1;
        bus.Instr      = 16'h5801;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        bus.InstrValid = 1'b0;
        bus.Instr      = '0;
        #1;
        nChecks++; if (bus.InstrReady !== 1'b1) begin nFails++; $display("FAIL rst_ready: got %b want 1", bus.InstrReady); end
        nChecks++; if (bus.En !== 1'b0) begin nFails++; $display("FAIL rst_en: got %b want 0", bus.En); end
        nChecks++; if (bus.Done !== 1'b0) begin nFails++; $display("FAIL rst_done: got %b want 0", bus.Done); end
        nChecks++; if (bus.Psr !== 5'h00) begin nFails++; $display("FAIL rst_psr: got %h want 00", bus.Psr); end
        nChecks++; if (bus.Result !== 16'h0000) begin nFails++; $display("FAIL rst_result: got %h want 0000", bus.Result); end
        nChecks++; if (bus.OpCode !== 5'h00 || bus.Imm_s !== 1'b0 || bus.Imm !== 16'h0000) begin
            nFails++; $display("FAIL rst_fields: opc=%h imms=%b imm=%h want 00/0/0000", bus.OpCode, bus.Imm_s, bus.Imm);
        end
        nChecks++; if (bus.RdestRegLoc !== 4'h0 || bus.RsrcRegLoc !== 4'h0) begin
            nFails++; $display("FAIL rst_regidx: rd=%h rs=%h want 0/0", bus.RdestRegLoc, bus.RsrcRegLoc);
        end
    endtask

    task automatic test_reg_add;
        preload(2, 16'd3);
        preload(1, 16'd4);
        runInstr(16'h0251);
        nChecks++; if (rOpc !== 5'h05 || rImmS !== 1'b0) begin nFails++; $display("FAIL add_decode: opc=%h imms=%b want 05/0", rOpc, rImmS); end
        nChecks++; if (rEnCnt !== 1 || rEnFirst !== 2) begin nFails++; $display("FAIL add_en: count=%0d first=N+%0d want 1 at N+2", rEnCnt, rEnFirst); end
        nChecks++; if (rDoneCnt !== 1 || rDoneLat !== 3) begin nFails++; $display("FAIL add_done: count=%0d at N+%0d want 1 at N+3", rDoneCnt, rDoneLat); end
        nChecks++; if (rRdyN3 !== 1'b1) begin nFails++; $display("FAIL add_ready_n3: got %b want 1", rRdyN3); end
        nChecks++; if (regs[2] !== 16'd7) begin nFails++; $display("FAIL add_r2: got %h want 0007", regs[2]); end
        nChecks++; if (bus.Result !== 16'd7) begin nFails++; $display("FAIL add_result: got %h want 0007", bus.Result); end
    endtask

    task automatic test_imm_add;
        preload(3, 16'd10);
        runInstr(16'h53FF);
        nChecks++; if (rImm !== 16'hFFFF || rImmS !== 1'b1) begin nFails++; $display("FAIL addi_imm: imm=%h imms=%b want FFFF/1", rImm, rImmS); end
        nChecks++; if (regs[3] !== 16'd9) begin nFails++; $display("FAIL addi_r3: got %h want 0009", regs[3]); end
        nChecks++; if (bus.Psr !== 5'h04) begin nFails++; $display("FAIL addi_psr: got %h want 04", bus.Psr); end
    endtask

    task automatic test_imm_and;
        preload(4, 16'h12FF);
        runInstr(16'h14F0);
        nChecks++; if (rImm !== 16'h00F0 || rOpc !== 5'h01) begin nFails++; $display("FAIL andi_imm: imm=%h opc=%h want 00F0/01", rImm, rOpc); end
        nChecks++; if (regs[4] !== 16'h00F0) begin nFails++; $display("FAIL andi_r4: got %h want 00F0", regs[4]); end
        nChecks++; if (bus.Psr !== 5'h00) begin nFails++; $display("FAIL andi_psr: got %h want 00", bus.Psr); end
    endtask

    task automatic test_cmp;
        preload(5, 16'd5);
        runInstr(16'hB505);
        nChecks++; if (rEnCnt !== 0) begin nFails++; $display("FAIL cmp_en: En cycles=%0d want 0", rEnCnt); end
        nChecks++; if (regs[5] !== 16'd5) begin nFails++; $display("FAIL cmp_r5: got %h want 0005", regs[5]); end
        nChecks++; if (bus.Psr !== 5'h01) begin nFails++; $display("FAIL cmp_psr: got %h want 01", bus.Psr); end
        nChecks++; if (bus.Result !== 16'h0000) begin nFails++; $display("FAIL cmp_result: got %h want 0000", bus.Result); end
        nChecks++; if (rDoneCnt !== 1 || rDoneLat !== 3) begin nFails++; $display("FAIL cmp_done: count=%0d at N+%0d want 1 at N+3", rDoneCnt, rDoneLat); end
    endtask

    task automatic test_back_to_back;
        logic [INSTR_W-1:0] words [4];
        int   idx, lastAcc, nopAcc;
        logic expRdy;
        words   = '{16'h0000, 16'h5601, 16'h5601, 16'h5602};
        idx     = 0;
        lastAcc = -10;
        nopAcc  = -10;
        @(negedge Clk);
        bus.InstrValid = 1'b1;
        bus.Instr      = words[0];
        for (int c = 0; c < 20 && idx < 4; c++) begin
            expRdy = (c - lastAcc >= 3);
            nChecks++; if (bus.InstrReady !== expRdy) begin nFails++; $display("FAIL b2b_ready c=%0d: got %b want %b", c, bus.InstrReady, expRdy); end
            if (c == nopAcc + 3) begin
                nChecks++; if (bus.Done !== 1'b1 || bus.Psr !== 5'h01) begin
                    nFails++; $display("FAIL nop_retire: done=%b psr=%h want 1/01", bus.Done, bus.Psr);
                end
            end
            if (bus.InstrReady === 1'b1) begin
                if (idx == 0) nopAcc = c;
                lastAcc = c;
                idx++;
            end
            @(negedge Clk);
            if (idx < 4) bus.Instr = words[idx];
            else begin
                bus.InstrValid = 1'b0;
                bus.Instr      = '0;
            end
        end
        nChecks++; if (idx !== 4 || lastAcc !== 9) begin nFails++; $display("FAIL b2b_accepts: n=%0d last=%0d want 4 at 9", idx, lastAcc); end
        repeat (2) @(negedge Clk);
        nChecks++; if (bus.Done !== 1'b1) begin nFails++; $display("FAIL b2b_done: got %b want 1", bus.Done); end
        nChecks++; if (regs[6] !== 16'd4) begin nFails++; $display("FAIL b2b_r6: got %h want 0004", regs[6]); end
        nChecks++; if (bus.Psr !== 5'h00) begin nFails++; $display("FAIL b2b_psr: got %h want 00", bus.Psr); end
    endtask

    task automatic test_reset_mid_exec;
        int doneSeen;
        runInstr(16'hB505);
        nChecks++; if (bus.Psr !== 5'h01) begin nFails++; $display("FAIL mid_pre_psr: got %h want 01", bus.Psr); end
        @(negedge Clk);
        bus.InstrValid = 1'b1;
        bus.Instr      = 16'h5801;
        @(negedge Clk);
        bus.InstrValid = 1'b0;
        bus.Instr      = '0;
        @(negedge Clk);
        nChecks++; if (bus.En !== 1'b1) begin nFails++; $display("FAIL mid_exec_en: got %b want 1", bus.En); end
        #2 Rst = 1'b1;
        #1;
        nChecks++; if (bus.En !== 1'b0) begin nFails++; $display("FAIL mid_rst_en: got %b want 0", bus.En); end
        nChecks++; if (bus.InstrReady !== 1'b1) begin nFails++; $display("FAIL mid_rst_idle: ready=%b want 1", bus.InstrReady); end
        nChecks++; if (bus.Psr !== 5'h00) begin nFails++; $display("FAIL mid_rst_psr: got %h want 00", bus.Psr); end
        @(negedge Clk);
        Rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.Done !== 1'b0) doneSeen++;
            @(negedge Clk);
        end
        nChecks++; if (doneSeen !== 0) begin nFails++; $display("FAIL mid_rst_done: pulses=%0d want 0", doneSeen); end
        nChecks++; if (regs[8] !== 16'h0000) begin nFails++; $display("FAIL mid_rst_r8: got %h want 0000", regs[8]); end
    endtask

    initial begin
        test_reset();
        test_reg_add();
        test_imm_add();
        test_imm_and();
        test_cmp();
        test_back_to_back();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/regfile_alu_seq.md
# regfile_alu_seq

Multi-cycle sequencer that owns the RegFile/ALU datapath pair. It accepts 16-bit instruction words over a valid/ready handshake and decodes register and immediate fields. It steps the datapath through operand-latch and execute cycles, so the registered ALU source is stable before write-back. It also captures the ALU flags into a program status register.

## Interface
- `DATA_W`, 16, datapath and immediate width
- `FLAG_W`, 5, width of the ALU flag vector and `Psr`
- `Clk` in 1: sole clock; all state updates on rising edge
- `Rst` in 1: asynchronous, active-high reset
- `InstrValid` in 1: `Instr` holds a valid word
- `InstrReady` out 1: sequencer can accept a word this cycle
- `Instr` in 16: instruction word
- `Flags` in FLAG_W: flag vector from the ALU (combinational)
- `AluOutput` in DATA_W: ALU result (combinational)
- `RdestRegLoc` out 4: destination/first-operand register index
- `RsrcRegLoc` out 4: source register index
- `OpCode` out 5: ALU operation
- `Imm` out DATA_W: extended immediate
- `Imm_s` out 1: 1 selects `Imm` as ALU source, 0 selects the register source
- `En` out 1: register-file write enable
- `Psr` out FLAG_W: latched flags
- `Result` out DATA_W: last written/compared ALU result
- `Done` out 1: one-cycle pulse per retired instruction

## Operation
- Format: `Instr[15:12]`=major, `[11:8]`=Rdest, `[7:4]`=ext, `[3:0]`=Rsrc; `[7:0]`=imm8 when major≠0.
- Register form (major=0): `OpCode`={0,ext}, `Imm_s`=0, `RsrcRegLoc`=`Instr[3:0]`.
- Immediate form (major≠0): `OpCode`={0,major}, `Imm_s`=1.
  - Codes AND=1, OR=2, XOR=3 zero-extend imm8.
  - All other codes sign-extend imm8.
- CMP (code 4'hB, either form): no write-back. `Psr` and `Result` still update.
- NOP (`Instr`=16'h0000): no write-back, `Psr` unchanged, `Done` still pulses.
- The decoded fields come from an internal instruction register latched on handshake. They are held constant from OPER through EXEC.
- FSM:
  - IDLE: `InstrReady`=1. `InstrValid`&`InstrReady` latches `Instr` → OPER.
  - OPER: fields driven; the datapath captures its ALU source on this cycle's closing edge → EXEC.
  - EXEC:
    - `En`=1 unless CMP/NOP; the register file writes `AluOutput` on the closing edge.
    - On that same edge: `Psr`←`Flags` (not for NOP), `Result`←`AluOutput`, `Done`←1.
    - → IDLE.
- `En` is decoded combinationally from state and the instruction register. It is never high outside EXEC.
- `InstrReady` is high only in IDLE. Words offered in OPER/EXEC are held off and not dropped.
- The sequencer never drives the datapath `Rst`.

## Timing
- Handshake in cycle N → OPER in N+1, EXEC in N+2.
- Write-back and `Psr` update occur on the edge ending N+2. `Done` is high during N+3.
- `InstrReady` is high again in N+3, so a new accept is possible in N+3.
- Throughput: one instruction per 3 cycles. Back-to-back dependent instructions need no hazard logic.
- Reset values:
  - state=IDLE, `InstrReady`=1, `En`=0, `Done`=0
  - `Psr`=0, `Result`=0, instruction register=16'h0000
  - so `OpCode`=0, `Imm_s`=0, `Imm`=0, register indices=0
- Reset mid-operation: asserting `Rst` in OPER/EXEC drops `En` immediately (asynchronous). The instruction is abandoned and no `Done` pulse occurs. The register file has already received `Rst` from the top level.
- `InstrValid` while `Rst`=1 is ignored.
- `Done` and `InstrReady` may both be high in N+3. A new accept in that cycle is legal.

## Structure
- Shared package `regfile_alu_pkg` holds:
  - FSM state enum (IDLE, OPER, EXEC)
  - opcode constants (ADD=5, SUB=9, CMP=11, AND=1, OR=2, XOR=3, MOV=13)
  - field-position constants
  - `is_logical` and `is_cmp` helper functions
- One natural sub-module: `instr_decode`, purely combinational. It maps the instruction register to `OpCode`, `Imm`, `Imm_s`, the register indices, and the write/no-write/NOP qualifiers.
- The FSM, handshake and `Psr`/`Result` registers stay in the top.

## Test plan
- Reset, then register-form ADD `Instr`=16'h0251 with R2=3, R1=4:
  - `En` high only in cycle N+2
  - R2=7 after
  - `Done` pulses in N+3
- Immediate ADD `Instr`=16'h53FF (R3=10): imm sign-extends to 16'hFFFF → R3=9.
- Immediate AND `Instr`=16'h14F0 (R4=16'h12FF): zero-extend → R4=16'h00F0.
- CMPI `Instr`=16'hB505 with R5=5:
  - `En` never asserted; R5 unchanged
  - `Psr` equals the ALU's equal-case flag vector
  - `Done` pulses
- NOP then hold `InstrValid` high continuously with three words:
  - each accepted exactly 3 cycles apart
  - `InstrReady` low in OPER/EXEC
  - `Psr` unchanged by the NOP
- Assert `Rst` asynchronously mid-EXEC:
  - `En` drops within the cycle; state=IDLE
  - `Psr`=0, no `Done` pulse
